uart_rx_frame_ctrl: RTL and testbench

//  Sequences reads from the UART receiver subsystem's RX FIFO and parses the

---
 rtl/uart_rx_frame_ctrl.sv | 95 +++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: pops the UART RX FIFO, parses SYNC/LEN/payload/CHK frames, streams payload and reports status
module uart_rx_frame_ctrl #(
  parameter int W = 8,
  parameter logic [W-1:0] SYNC = 'hA5,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         rx_empty,
  input  logic [W-1:0] r_data,
  output logic         rd_uart,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         frame_ok,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic [7:0]   frame_cnt,
  output logic [7:0]   err_cnt
);
  localparam int TW = $clog2(TIMEOUT) < 1 ? 1 : $clog2(TIMEOUT);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;
  state_t state;
  logic [W-1:0] rem, chk;
  logic [TW-1:0] timer;
  logic bad_len, timeout;
  function automatic logic [7:0] sat(input logic [7:0] c);
    return c == 8'hFF ? c : c + 8'd1;
  endfunction
  always_comb begin
    m_valid = state == PAYLOAD && !rx_empty;
    m_data  = r_data;
    m_last  = state == PAYLOAD && rem == W'(1);
    rd_uart = !reset && !rx_empty && (state == HUNT ? en : state == PAYLOAD ? m_ready : 1'b1);
    bad_len = r_data == '0 || r_data > W'(MAX_LEN);
    timeout = state != HUNT && rx_empty && timer == TW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= HUNT;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      rem       <= '0;
      chk       <= '0;
      timer     <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      // every state change coincides with a pop or a timeout, so this also clears on state change
      timer <= (state == HUNT || rd_uart || timeout) ? '0 : rx_empty ? timer + 1'b1 : timer;
      if (timeout) begin
        state     <= HUNT;
        err_code  <= 2'd3;
        frame_err <= 1'b1;
        err_cnt   <= sat(err_cnt);
      end else if (rd_uart)
        case (state)
          HUNT: if (r_data == SYNC) state <= LEN;
          LEN:
            if (bad_len) begin
              state     <= HUNT;
              err_code  <= 2'd1;
              frame_err <= 1'b1;
              err_cnt   <= sat(err_cnt);
            end else begin
              rem   <= r_data;
              chk   <= r_data;
              state <= PAYLOAD;
            end
          PAYLOAD: begin
            chk <= chk ^ r_data;
            rem <= rem - 1'b1;
            if (rem == W'(1)) state <= CHK;
          end
          CHK: begin
            state <= HUNT;
            if (r_data == chk) begin
              frame_ok  <= 1'b1;
              frame_cnt <= sat(frame_cnt);
            end else begin
              err_code  <= 2'd2;
              frame_err <= 1'b1;
              err_cnt   <= sat(err_cnt);
            end
          end
          default: state <= HUNT;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames through a FIFO model, scoreboard of expected beats and status pulses
module tb_uart_rx_frame_ctrl;
  localparam int TO = 20;
  logic clk = 0, reset = 1, en = 1, rx_empty = 1, m_ready = 1;
  logic [7:0] r_data = 0;
  logic rd_uart, m_valid, m_last, frame_ok, frame_err;
  logic [7:0] m_data, frame_cnt, err_cnt;
  logic [1:0] err_code;
  typedef struct packed {logic [1:0] kind; logic [1:0] code; logic [7:0] data; logic last;} ev_t;
  ev_t exp_q[$];
  logic [7:0] fifo[$];
  int vectors = 0, miscompares = 0, ready_mode = 0;

  uart_rx_frame_ctrl #(.W(8), .SYNC(8'hA5), .MAX_LEN(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  function void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function void ex(input logic [1:0] k, input logic [1:0] c, input logic [7:0] d, input logic l);
    exp_q.push_back(ev_t'{kind: k, code: c, data: d, last: l});
  endfunction

  function void got(input string name, input ev_t e);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_%s: got %0h expected nothing", name, e);
    end else check(name, 32'(e), 32'(exp_q.pop_front()));
  endfunction

  task automatic feed(input logic [7:0] bs[$]);
    foreach (bs[i]) fifo.push_back(bs[i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({name, "_done"}, 32'(n < 500), 1);
  endtask

  // FIFO model: head changes just after the edge that consumed it
  initial forever begin
    @(posedge clk);
    if (rd_uart && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    rx_empty = fifo.size() == 0;
    r_data = rx_empty ? 8'h00 : fifo[0];
    m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~m_ready : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (rd_uart && rx_empty) begin
        miscompares++;
        $display("FAIL pop_when_empty: got rd_uart=1 expected 0");
      end
      if (m_valid && !m_ready && rd_uart) begin
        miscompares++;
        $display("FAIL pop_without_ready: got rd_uart=1 expected 0");
      end
      if (frame_ok && frame_err) begin
        miscompares++;
        $display("FAIL ok_and_err: got both 1 expected exclusive");
      end
      if (m_valid && m_ready) got("beat", ev_t'{kind: 2'd0, code: 2'd0, data: m_data, last: m_last});
      if (frame_ok) got("frame_ok", ev_t'{kind: 2'd1, code: 2'd0, data: 8'd0, last: 1'b0});
      if (frame_err) got("frame_err", ev_t'{kind: 2'd2, code: err_code, data: 8'd0, last: 1'b0});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic case1_expect();
    ex(0, 0, 8'h11, 0); ex(0, 0, 8'h22, 0); ex(0, 0, 8'h33, 1); ex(1, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rd_uart", 32'(rd_uart), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_status", {frame_ok, frame_err, err_code}, 0);
    check("rst_counts", {frame_cnt, err_cnt}, 0);
    reset = 0;
    // en low: bytes must stay in the FIFO
    en = 0;
    feed('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    repeat (6) @(negedge clk);
    check("en_hold_fifo", 32'(fifo.size()), 6);
    check("en_hold_valid", 32'(m_valid), 0);
    en = 1;
    case1_expect();
    drain("case1");
    check("case1_frame_cnt", 32'(frame_cnt), 1);
    feed('{8'h00, 8'h7F, 8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD});
    ex(0, 0, 8'hAA, 0); ex(0, 0, 8'h55, 1); ex(1, 0, 0, 0);
    drain("case2");
    check("case2_fifo_left", 32'(fifo.size()), 0);
    check("case2_frame_cnt", 32'(frame_cnt), 2);
    feed('{8'hA5, 8'h00, 8'hA5, 8'h11});
    ex(2, 1, 0, 0); ex(2, 1, 0, 0);
    drain("case3");
    check("case3_err_cnt", 32'(err_cnt), 2);
    check("case3_err_code", 32'(err_code), 1);
    feed('{8'hA5, 8'h01, 8'h42, 8'h00});
    ex(0, 0, 8'h42, 1); ex(2, 2, 0, 0);
    drain("case4");
    check("case4_counts", {frame_cnt, err_cnt}, {8'd2, 8'd3});
    feed('{8'hA5, 8'h02, 8'h10});
    ex(0, 0, 8'h10, 0); ex(2, 3, 0, 0);
    drain("case5");
    check("case5_err_code", 32'(err_code), 3);
    check("case5_err_cnt", 32'(err_cnt), 4);
    feed('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    case1_expect();
    drain("case5_recover");
    check("case5_frame_cnt", 32'(frame_cnt), 3);
    ready_mode = 1;
    feed('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    case1_expect();
    drain("case6");
    check("case6_counts", {frame_cnt, err_cnt}, {8'd4, 8'd4});
    // reset while a payload byte is being offered
    ready_mode = 2;
    feed('{8'hA5, 8'h03, 8'h11});
    repeat (6) @(negedge clk);
    check("stall_valid", 32'(m_valid), 1);
    check("stall_data", 32'(m_data), 32'h11);
    check("stall_fifo", 32'(fifo.size()), 1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("midrst_valid", {m_valid, m_last, rd_uart}, 0);
    check("midrst_status", {frame_ok, frame_err, err_code}, 0);
    check("midrst_counts", {frame_cnt, err_cnt}, 0);
    fifo.delete();
    exp_q.delete();
    ready_mode = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    feed('{8'h00, 8'h7F, 8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD});
    ex(0, 0, 8'hAA, 0); ex(0, 0, 8'h55, 1); ex(1, 0, 0, 0);
    drain("post_reset");
    check("post_reset_frame_cnt", 32'(frame_cnt), 1);
    check("leftover_expected", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
